// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider owning Y and Z_HI/Z_LO
// Magnitudes are iterated in CALC; signs and special cases are resolved in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] bus_Data,
  input  logic             Y_enable,
  input  logic             start,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] Y_Data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Z_HI_Data,
  output logic [WIDTH-1:0] Z_LO_Data
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_q, y_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   z_hi_q, z_hi_d, z_lo_q, z_lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               done_q, done_d, dz_q, dz_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sgn_a     = op[0] & y_q[WIDTH-1];
    sgn_b     = op[0] & bus_Data[WIDTH-1];
    mag_a     = sgn_a ? -y_q : y_q;
    mag_b     = sgn_b ? -bus_Data : bus_Data;
    // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & a_q};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_q};
    prod      = (op_q[0] & (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo       = (op_q[0] & (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = (op_q[0] & sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    z_hi_d  = z_hi_q;
    z_lo_d  = z_lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    if (Y_enable) y_d = bus_Data;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          sa_d  = sgn_a;
          sb_d  = sgn_b;
          a_d   = mag_a;
          b_d   = mag_b;
          cnt_d = '0;
          if (op[1] && (bus_Data == '0)) begin
            // Divide by zero: preload the final Z pair, skip the iterations
            acc_d   = {y_q, {WIDTH{1'b1}}};
            state_d = FIX;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[1]) begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q[1] && (b_q == '0)) begin
          {z_hi_d, z_lo_d} = acc_q;
          dz_d             = 1'b1;
        end else if (op_q[1]) begin
          z_hi_d = rem;
          z_lo_d = quo;
          dz_d   = 1'b0;
        end else begin
          {z_hi_d, z_lo_d} = prod;
          dz_d             = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      z_hi_q  <= '0;
      z_lo_q  <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      z_hi_q  <= z_hi_d;
      z_lo_q  <= z_lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign Y_Data    = y_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign Z_HI_Data = z_hi_q;
  assign Z_LO_Data = z_lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        clr0, ye0, start0, busy0, done0, dz0;
  logic [1:0]  opc0;
  logic [31:0] bus0, y0, zh0, zl0;
  logic        clr1, ye1, start1, busy1, done1, dz1;
  logic [1:0]  opc1;
  logic [7:0]  bus1, y1, zh1, zl1;

  muldiv_unit #(.WIDTH(32)) dut0 (
    .clk(clk), .clr(clr0), .bus_Data(bus0), .Y_enable(ye0), .start(start0), .op(opc0),
    .Y_Data(y0), .busy(busy0), .done(done0), .div_zero(dz0), .Z_HI_Data(zh0), .Z_LO_Data(zl0)
  );

  muldiv_unit #(.WIDTH(8)) dut1 (
    .clk(clk), .clr(clr1), .bus_Data(bus1), .Y_enable(ye1), .start(start1), .op(opc1),
    .Y_Data(y1), .busy(busy1), .done(done1), .div_zero(dz1), .Z_HI_Data(zh1), .Z_LO_Data(zl1)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
    string       nm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic pd0 = 1'b0;
  logic pd1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      chk("w32 done pulse width", {63'b0, pd0}, 64'd0);
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w32 unexpected done: got Z %0h_%0h expected no completion", zh0, zl0);
      end else begin
        e = q0.pop_front();
        chk({e.nm, " Z_HI"}, {32'b0, zh0}, {32'b0, e.hi});
        chk({e.nm, " Z_LO"}, {32'b0, zl0}, {32'b0, e.lo});
        chk({e.nm, " div_zero"}, {63'b0, dz0}, {63'b0, e.dz});
        chk({e.nm, " done cycle"}, 64'(cyc), 64'(e.due));
      end
    end
    if (done1) begin
      chk("w8 done pulse width", {63'b0, pd1}, 64'd0);
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8 unexpected done: got Z %0h_%0h expected no completion", zh1, zl1);
      end else begin
        e = q1.pop_front();
        chk({e.nm, " Z_HI"}, {56'b0, zh1}, {32'b0, e.hi});
        chk({e.nm, " Z_LO"}, {56'b0, zl1}, {32'b0, e.lo});
        chk({e.nm, " div_zero"}, {63'b0, dz1}, {63'b0, e.dz});
        chk({e.nm, " done cycle"}, 64'(cyc), 64'(e.due));
      end
    end
    pd0 <= done0;
    pd1 <= done1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_y(input int d, input logic [31:0] v);
    if (d == 0) begin ye0 = 1'b1; bus0 = v; end
    else begin ye1 = 1'b1; bus1 = v[7:0]; end
    tick();
    ye0 = 1'b0;
    ye1 = 1'b0;
  endtask

  task automatic go(input int d, input logic [31:0] b, input logic [1:0] o, input bit push,
                    input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                    input int lat, input string nm);
    exp_t e;
    e.hi  = hi;
    e.lo  = lo;
    e.dz  = dz;
    e.due = cyc + 1 + lat;
    e.nm  = nm;
    if (d == 0) begin
      start0 = 1'b1; bus0 = b; opc0 = o;
      if (push) q0.push_back(e);
    end else begin
      start1 = 1'b1; bus1 = b[7:0]; opc1 = o;
      if (push) q1.push_back(e);
    end
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int busy_cycles, input string nm);
    int n = 0;
    int bz = 0;
    bit seen = 1'b0;
    while (n < 200 && !seen) begin
      if ((d == 0) ? done0 : done1) seen = 1'b1;
      else begin
        if ((d == 0) ? busy0 : busy1) bz++;
        n++;
        tick();
      end
    end
    chk({nm, " completed"}, {63'b0, seen}, 64'd1);
    chk({nm, " busy cycles"}, 64'(bz), 64'(busy_cycles));
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                     input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                     input int lat, input string nm);
    load_y(d, a);
    go(d, b, o, 1'b1, hi, lo, dz, lat, nm);
    wait_done(d, lat, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 1 ms");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    clr0 = 1'b1; ye0 = 1'b0; start0 = 1'b0; opc0 = 2'b00; bus0 = '0;
    clr1 = 1'b1; ye1 = 1'b0; start1 = 1'b0; opc1 = 2'b00; bus1 = '0;
    repeat (3) tick();
    chk("reset Y", {32'b0, y0}, 64'd0);
    chk("reset busy", {63'b0, busy0}, 64'd0);
    chk("reset done", {63'b0, done0}, 64'd0);
    chk("reset div_zero", {63'b0, dz0}, 64'd0);
    chk("reset Z", {zh0, zl0}, 64'd0);
    chk("reset w8 Z", {48'b0, zh1, zl1}, 64'd0);
    clr0 = 1'b0;
    clr1 = 1'b0;
    tick();

    run(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, "umul max");
    run(0, 32'hFFFF_FFFD, 32'd7, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, "smul -3*7");
    run(0, 32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 32'h0, 1'b0, 33, "smul minneg^2");
    run(0, 32'h1234_5678, 32'h10, 2'b00, 32'h1, 32'h2345_6780, 1'b0, 33, "umul shift");
    run(0, 32'hFFFF_FFF9, 32'd2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, "sdiv -7/2");
    run(0, 32'd7, 32'hFFFF_FFFE, 2'b11, 32'h1, 32'hFFFF_FFFD, 1'b0, 33, "sdiv 7/-2");
    run(0, 32'd100, 32'd7, 2'b10, 32'd2, 32'd14, 1'b0, 33, "udiv 100/7");
    run(0, 32'hFFFF_FFFF, 32'h10, 2'b10, 32'hF, 32'h0FFF_FFFF, 1'b0, 33, "udiv max/16");
    run(0, 32'd5, 32'd0, 2'b10, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, "udiv 5/0");
    run(0, 32'd9, 32'd3, 2'b10, 32'd0, 32'd3, 1'b0, 33, "udiv 9/3");
    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'd0, 32'h8000_0000, 1'b0, 33, "sdiv overflow");
    run(0, 32'hFFFF_FFFB, 32'd0, 2'b11, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1, "sdiv -5/0");

    load_y(0, 32'd6);
    ye0 = 1'b1;
    go(0, 32'd7, 2'b00, 1'b1, 32'd0, 32'd42, 1'b0, 33, "Y load with start");
    ye0 = 1'b0;
    chk("Y takes bus at start edge", {32'b0, y0}, 64'd7);
    wait_done(0, 33, "Y load with start");

    load_y(0, 32'h0001_0000);
    go(0, 32'h0001_0000, 2'b00, 1'b1, 32'd1, 32'd0, 1'b0, 33, "mul with mid-op Y and start");
    repeat (2) tick();
    ye0 = 1'b1;
    bus0 = 32'hDEAD_BEEF;
    tick();
    ye0 = 1'b0;
    go(0, 32'd3, 2'b01, 1'b0, 32'd0, 32'd0, 1'b0, 0, "ignored start");
    wait_done(0, 29, "mul with mid-op Y and start");
    chk("Y loaded mid-op", {32'b0, y0}, 64'hDEAD_BEEF);
    repeat (40) tick();

    run(0, 32'd5, 32'd0, 2'b10, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, "div0 before clr");
    load_y(0, 32'd3);
    go(0, 32'd5, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 0, "aborted mul");
    repeat (9) tick();
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("clr busy", {63'b0, busy0}, 64'd0);
    chk("clr Z", {zh0, zl0}, 64'd0);
    chk("clr Y", {32'b0, y0}, 64'd0);
    chk("clr div_zero", {63'b0, dz0}, 64'd0);
    repeat (40) tick();
    run(0, 32'd6, 32'hFFFF_FFF9, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 33, "mul after clr");

    run(1, 32'hFF, 32'hFF, 2'b00, 32'hFE, 32'h01, 1'b0, 9, "w8 umul FF*FF");
    go(1, 32'h02, 2'b11, 1'b1, 32'hFF, 32'h00, 1'b0, 9, "w8 back-to-back sdiv -1/2");
    wait_done(1, 9, "w8 back-to-back sdiv -1/2");
    run(1, 32'h80, 32'hFF, 2'b11, 32'h00, 32'h80, 1'b0, 9, "w8 sdiv overflow");
    run(1, 32'h80, 32'h00, 2'b11, 32'h80, 32'hFF, 1'b1, 1, "w8 sdiv by zero");

    repeat (5) tick();
    chk("w32 scoreboard drained", 64'(q0.size()), 64'd0);
    chk("w8 scoreboard drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
